audio_pdm_dac: RTL

Audio output stage of the chip: accepts 8-bit offset-binary samples over a valid/ready stream and converts them to a 1-bit pulse-density (PDM) pin through a first-order delta-sigma modulator. A two-entry buffer absorbs producer jitter, and a sample-rate divider paces consumption. The block sits downstream of the on-chip sample source (counter/test-tone logic or `ui_in` sample path); `pdm_out` drives an output pin feeding an external RC low-pass filter.

---
 rtl/audio_pkg.sv | 12 +
 rtl/audio_fifo2.sv | 50 +++++
 rtl/audio_pdm_dac.sv | 115 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the PDM audio output stage.
// No logic; no latency; no backpressure.
package audio_pkg;
  localparam int AUDIO_DW = 8;
  localparam logic [AUDIO_DW-1:0] AUDIO_MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PLAY = 2'd2
  } pdm_state_t;
endpackage

// File: rtl/audio_fifo2.sv
// Two-entry sample buffer with push/pop/flush; head_dat is the oldest entry.
// Latency: push visible in level one edge later; flush beats push; pop on empty is ignored.
module audio_fifo2 import audio_pkg::*; #(
  parameter int W = AUDIO_DW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   level
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_push;
  logic         do_pop;

  assign do_push  = push && (level != 2'd2);
  assign do_pop   = pop && (level != 2'd0);
  assign head_dat = slot0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      level <= 2'd0;
    end else if (do_push && !do_pop) begin
      level <= level + 2'd1;
    end else if (do_pop && !do_push) begin
      level <= level - 2'd1;
    end
  end

  // Simultaneous push and pop can only happen at level 1: new data becomes head.
  always_ff @(posedge clk) begin
    if (!flush) begin
      case ({do_push, do_pop})
        2'b10: begin
          if (level == 2'd0) slot0 <= push_dat;
          else               slot1 <= push_dat;
        end
        2'b01:   slot0 <= slot1;
        2'b11:   slot0 <= push_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/audio_pdm_dac.sv
// Sample stream to 1-bit first-order delta-sigma PDM pin; AUDIO_UNDERRUN_MUTE_EN mutes to midscale on underrun.
// Latency: tick edge loads cur, pdm_out reflects it from the following edge.
// Backpressure: s_ready drops while the 2-entry buffer is full.
module audio_pdm_dac import audio_pkg::*; #(
  parameter int SAMPLE_DIV = 625,
  parameter int DW         = AUDIO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          clr_underrun,
  output logic          pdm_out,
  output logic          sample_tick,
  output logic          underrun,
  output logic [1:0]    level
);

  localparam logic [15:0]   DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] MID      = DW'(AUDIO_MIDSCALE);

  pdm_state_t    state;
  pdm_state_t    state_nxt;
  logic [15:0]   div;
  logic [DW-1:0] acc;
  logic [DW-1:0] cur;
  logic [DW-1:0] head_dat;
  logic [DW:0]   sum;
  logic          push;
  logic          pop;
  logic          flush;
  logic          tick_act;
  logic          starve;

  assign s_ready = (level != 2'd2);
  assign push    = s_valid && s_ready;

  audio_fifo2 #(.W(DW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .push_dat (s_data),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (level)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = FILL;
        FILL:    if (level == 2'd2) state_nxt = PLAY;
        PLAY:    state_nxt = PLAY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A tick in the same cycle as an enable drop is swallowed by the flush.
  always_comb begin
    sample_tick = (state == PLAY) && (div == DIV_LAST);
    flush       = !enable;
    tick_act    = sample_tick && enable;
    pop         = tick_act && (level != 2'd0);
    starve      = tick_act && (level == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable || (state != PLAY)) div <= '0;
    else if (div == DIV_LAST)                div <= '0;
    else                                     div <= div + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cur <= MID;
    end else if (pop) begin
      cur <= head_dat;
`ifdef AUDIO_UNDERRUN_MUTE_EN
    end else if (starve) begin
      cur <= MID;
`endif
    end
  end

  assign sum = {1'b0, acc} + {1'b0, cur};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else begin
      acc     <= sum[DW-1:0];
      pdm_out <= sum[DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             underrun <= 1'b0;
    else if (starve)       underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
  end

endmodule
